// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO accumulator registers.
// Arithmetic is combinational on the captured operands; a down-counter sets the busy latency.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [W2-1:0]    acc_q;

  logic                    signed_op_d;
  logic [W2-1:0]           a_ext_d;
  logic [W2-1:0]           b_ext_d;
  logic [W2-1:0]           prod_d;
  logic                    b_nz_d;
  logic                    sdiv_ovf_d;
  logic [WIDTH-1:0]        udiv_b_d;
  logic [WIDTH-1:0]        sdiv_b_d;
  logic [WIDTH-1:0]        uq_d;
  logic [WIDTH-1:0]        ur_d;
  logic signed [WIDTH-1:0] sq_d;
  logic signed [WIDTH-1:0] sr_d;
  logic [W2-1:0]           result_d;

  // Result of the in-flight op, computed from the values captured at start.
  always_comb begin
    signed_op_d = ~op_q[0];
    a_ext_d     = {{WIDTH{signed_op_d & a_q[WIDTH-1]}}, a_q};
    b_ext_d     = {{WIDTH{signed_op_d & b_q[WIDTH-1]}}, b_q};
    prod_d      = a_ext_d * b_ext_d;
    b_nz_d      = (b_q != ZERO);
    sdiv_ovf_d  = (a_q == MOST_NEG) && (b_q == ONES);
    // Divisors are steered to 1 on the special cases so no real divide ever sees 0 or overflows.
    udiv_b_d    = b_nz_d ? b_q : ONE;
    sdiv_b_d    = (b_nz_d && !sdiv_ovf_d) ? b_q : ONE;
    uq_d        = a_q / udiv_b_d;
    ur_d        = a_q % udiv_b_d;
    sq_d        = $signed(a_q) / $signed(sdiv_b_d);
    sr_d        = $signed(a_q) % $signed(sdiv_b_d);
    result_d    = acc_q;
    case (op_q)
      4'd0, 4'd1: result_d = prod_d;
      4'd4, 4'd5: result_d = acc_q + prod_d;
      4'd6, 4'd7: result_d = acc_q - prod_d;
      4'd2: begin
        if (!b_nz_d) begin
          result_d = {a_q, ONES};
        end else if (sdiv_ovf_d) begin
          result_d = {ZERO, a_q};
        end else begin
          result_d = {sr_d, sq_d};
        end
      end
      4'd3: begin
        if (!b_nz_d) begin
          result_d = {a_q, ONES};
        end else begin
          result_d = {ur_d, uq_d};
        end
      end
      default: result_d = acc_q;
    endcase
  end

  // Control FSM, latency counter, operand capture and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= ZERO;
      lo_q    <= ZERO;
      a_q     <= ZERO;
      b_q     <= ZERO;
      op_q    <= 4'd0;
      acc_q   <= {W2{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (md_op)
              4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= md_op;
                acc_q   <= {hi_q, lo_q};
                cnt_q   <= CW'(MULT_CYC);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
              4'd2, 4'd3: begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= md_op;
                acc_q   <= {hi_q, lo_q};
                cnt_q   <= CW'(DIV_CYC);
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
              4'd8:    hi_q <= A;
              4'd9:    lo_q <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // Starts are not looked at here, so anything issued while busy is dropped.
          if (cnt_q == CW'(1)) begin
            {hi_q, lo_q} <= result_d;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/busy-length are queued at issue
// and checked by a monitor whenever busy falls.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A_s, B_s;
  logic        busy;
  logic [31:0] HI, LO;

  logic        start2;
  logic [3:0]  md_op2;
  logic [31:0] A2, B2;
  logic        busy2;
  logic [31:0] HI2, LO2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   run_len   = 0;
  logic prev_busy = 1'b0;
  logic seen25    = 1'b0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .A(A_s), .B(B_s), .busy(busy), .HI(HI), .LO(LO)
  );

  md_unit #(.WIDTH(32), .MULT_CYC(1), .DIV_CYC(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .md_op(md_op2),
    .A(A2), .B(B2), .busy(busy2), .HI(HI2), .LO(LO2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation each time busy drops.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (LO == 32'd25) seen25 = 1'b1;
      if (busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
          check({e.name, "_busy_len"}, 64'(run_len), 64'(e.len));
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic expect_res(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input int len);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.len = len;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op = op; A_s = a; B_s = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    if (sb.size() != 0 || busy) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; md_op = 4'd0; A_s = 32'd0; B_s = 32'd0;
    start2 = 1'b0; md_op2 = 4'd0; A2 = 32'd0; B2 = 32'd0;
    #12;
    check("reset_hi", {32'd0, HI}, 64'd0);
    check("reset_lo", {32'd0, LO}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    expect_res("mult", 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    do_op(4'd0, 32'hFFFFFFFF, 32'd2); wait_done("mult");
    expect_res("multu", 32'h00000001, 32'hFFFFFFFE, 5);
    do_op(4'd1, 32'hFFFFFFFF, 32'd2); wait_done("multu");
    expect_res("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    do_op(4'd0, 32'hFFFFFFFD, 32'd5); wait_done("mult_neg");
    expect_res("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    do_op(4'd2, 32'hFFFFFFF9, 32'd2); wait_done("div");
    expect_res("divu_by0", 32'd7, 32'hFFFFFFFF, 10);
    do_op(4'd3, 32'd7, 32'd0); wait_done("divu_by0");

    do_op(4'd8, 32'd0, 32'd0);
    check("mthi", {32'd0, HI}, 64'd0);
    do_op(4'd9, 32'hFFFFFFFF, 32'd0);
    check("mtlo", {32'd0, LO}, {32'd0, 32'hFFFFFFFF});
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    expect_res("madd", 32'd1, 32'd0, 5);
    do_op(4'd4, 32'd1, 32'd1); wait_done("madd");
    expect_res("msub", 32'd0, 32'hFFFFFFFE, 5);
    do_op(4'd6, 32'd1, 32'd2); wait_done("msub");

    // Second start two cycles into a divide must be dropped.
    expect_res("div_ignore", 32'd2, 32'd14, 10);
    do_op(4'd2, 32'd100, 32'd7);
    md_op = 4'd0; A_s = 32'd3; B_s = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("div_ignore");

    // Reset in busy cycle 3 of 5*5 with HI/LO preloaded to 9.
    do_op(4'd8, 32'd9, 32'd0);
    do_op(4'd9, 32'd9, 32'd0);
    seen25 = 1'b0;
    do_op(4'd0, 32'd5, 32'd5);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_hi", {32'd0, HI}, 64'd0);
    check("abort_lo", {32'd0, LO}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    md_op = 4'd9; A_s = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no25", {63'd0, seen25}, 64'd0);
    check("abort_lo_after", {32'd0, LO}, 64'd0);
    check("abort_busy_after", {63'd0, busy}, 64'd0);

    expect_res("div_ovf", 32'd0, 32'h80000000, 10);
    do_op(4'd2, 32'h80000000, 32'hFFFFFFFF); wait_done("div_ovf");
    do_op(4'd12, 32'h1234, 32'h5678);
    check("noop_hi", {32'd0, HI}, 64'd0);
    check("noop_lo", {32'd0, LO}, {32'd0, 32'h80000000});
    check("noop_busy", {63'd0, busy}, 64'd0);

    // Minimum latency instance.
    @(negedge clk);
    md_op2 = 4'd2; A2 = 32'h80000000; B2 = 32'hFFFFFFFF; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("c1_div_busy", {63'd0, busy2}, 64'd1);
    check("c1_div_hold_lo", {32'd0, LO2}, 64'd0);
    @(negedge clk);
    check("c1_div_busy_fall", {63'd0, busy2}, 64'd0);
    check("c1_div_lo", {32'd0, LO2}, {32'd0, 32'h80000000});
    check("c1_div_hi", {32'd0, HI2}, 64'd0);
    md_op2 = 4'd1; A2 = 32'd6; B2 = 32'd7; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("c1_mul_busy", {63'd0, busy2}, 64'd1);
    @(negedge clk);
    check("c1_mul_busy_fall", {63'd0, busy2}, 64'd0);
    check("c1_mul_lo", {32'd0, LO2}, 64'd42);
    check("c1_mul_hi", {32'd0, HI2}, 64'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
